// File: rtl/oled_spi_tx.sv
// SSD1331 4-wire SPI byte transmitter with built-in panel RES sequencing.
// One byte plus D/C flag per valid/ready handshake, MSB first, SPI mode 0.
module oled_spi_tx #(
  parameter int CLK_DIV  = 10,
  parameter int CS_GAP   = 2,
  parameter int RES_LOW  = 25000,
  parameter int RES_WAIT = 25000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       init_done,
  output logic       DIN,
  output logic       OLED_CLK,
  output logic       CS,
  output logic       DC,
  output logic       RES,
  output logic [2:0] state_dbg
);

  // Handshake: a byte is taken on any posedge where tx_valid && tx_ready;
  // tx_ready is a registered flag that only rises in IDLE, and upstream must
  // hold tx_data/tx_dc stable while tx_valid is high and tx_ready is low.

  localparam int MAX_RES = (RES_LOW > RES_WAIT) ? RES_LOW : RES_WAIT;
  localparam int MAX_BIT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_MAX = (MAX_RES > MAX_BIT) ? MAX_RES : MAX_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RES_LO_LAST = CNT_W'(RES_LOW - 1);
  localparam logic [CNT_W-1:0] RES_HI_LAST = CNT_W'(RES_WAIT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_RES_LO = 3'd0,
    S_RES_HI = 3'd1,
    S_IDLE   = 3'd2,
    S_BIT_LO = 3'd3,
    S_BIT_HI = 3'd4,
    S_HOLD   = 3'd5,
    S_GAP    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       sh_q, sh_d;
  logic             ready_q, ready_d;
  logic             init_q, init_d;
  logic             din_q, din_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             res_q, res_d;

  assign tx_ready  = ready_q;
  assign init_done = init_q;
  assign DIN       = din_q;
  assign OLED_CLK  = sclk_q;
  assign CS        = cs_q;
  assign DC        = dc_q;
  assign RES       = res_q;
  assign state_dbg = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RES_LO;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b0;
      init_q  <= 1'b0;
      din_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ready_q <= ready_d;
      init_q  <= init_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ready_d = ready_q;
    init_d  = init_q;
    din_d   = din_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    res_d   = res_q;

    // Every phase counts 0..LAST from its entry edge and clears on exit.
    case (state_q)
      S_RES_LO: begin
        if (cnt_q == RES_LO_LAST) begin
          res_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RES_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RES_HI: begin
        if (cnt_q == RES_HI_LAST) begin
          init_d  = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          // Bit 7 goes straight to DIN; the shifter keeps only bits 6..0.
          sh_d    = tx_data[6:0];
          din_d   = tx_data[7];
          dc_d    = tx_dc;
          cs_d    = 1'b0;
          ready_d = 1'b0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_BIT_LO;
        end
      end
      S_BIT_LO: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_BIT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BIT_HI: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            din_d   = sh_q[6];
            sh_d    = {sh_q[5:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            state_d = S_BIT_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RES_LO;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: reset sequencing, byte serialization,
// back-to-back streaming, ignored early requests and mid-byte reset.
module tb_oled_spi_tx;
  localparam int CLK_DIV  = 2;
  localparam int CS_GAP   = 1;
  localparam int RES_LOW  = 4;
  localparam int RES_WAIT = 3;
  localparam int LAT      = 17 * CLK_DIV + CS_GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, init_done, din, oled_clk, cs, dc, res;
  logic [2:0] state_dbg;

  oled_spi_tx #(
    .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .RES_LOW(RES_LOW), .RES_WAIT(RES_WAIT)
  ) dut (
    .CLK(clk), .RST(rst), .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .init_done(init_done), .DIN(din), .OLED_CLK(oled_clk),
    .CS(cs), .DC(dc), .RES(res), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         n_checks = 0;
  int         n_pass = 0;
  int         viol = 0;
  int         rise_cnt = 0;
  int         rx_n = 0;
  logic [7:0] rx = 8'h00;
  logic       rx_dc = 1'b0;
  logic       p_clk, p_din, p_dc, p_cs;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock step; samples 1ns after the edge and captures bits on OLED_CLK rises.
  task automatic tick();
    logic rising, falling;
    @(posedge clk);
    #1;
    rising  = (oled_clk === 1'b1) && (p_clk === 1'b0);
    falling = (oled_clk === 1'b0) && (p_clk === 1'b1);
    if (((din !== p_din) || (dc !== p_dc)) && !(falling || cs === 1'b1 || p_cs === 1'b1))
      viol++;
    if (rising) begin
      rise_cnt++;
      if (cs !== 1'b0) viol++;
      if (rx_n == 0) rx_dc = dc;
      else if (dc !== rx_dc) viol++;
      rx = {rx[6:0], din};
      rx_n++;
      if (rx_n == 8) begin
        got_q.push_back({rx_dc, rx});
        rx_n = 0;
      end
    end
    p_clk = oled_clk;
    p_din = din;
    p_dc  = dc;
    p_cs  = cs;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (tx_ready !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    tx_data  = b;
    tx_dc    = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    exp_q.push_back({d, b});
    check("accept_cs", cs, 1'b0);
    check("accept_din_msb", din, b[7]);
    check("accept_dc", dc, d);
    check("accept_ready_low", tx_ready, 1'b0);
  endtask

  initial begin
    int lat, n, gap, r0, t_res, cs_bad;
    bit seen_high;

    // 1: reset values and RES sequencing
    rst = 1'b1;
    tick();
    check("rst_res", res, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_oled_clk", oled_clk, 1'b0);
    check("rst_din", din, 1'b0);
    check("rst_dc", dc, 1'b0);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_init", init_done, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("res_low_3", res, 1'b0);
    tick();
    check("res_high_4", res, 1'b1);
    tick();
    tick();
    check("init_not_yet", init_done, 1'b0);
    tick();
    check("init_done", init_done, 1'b1);
    check("init_ready", tx_ready, 1'b1);
    check("init_state_idle", state_dbg, 3'd2);

    // 2: single command byte
    send(8'hA5, 1'b0);
    wait_ready(lat);
    check("a5_latency", lat, LAT);
    check("a5_din_hold", din, 1'b1);
    check("a5_cs_idle", cs, 1'b1);
    check("a5_clk_idle", oled_clk, 1'b0);

    // 3: tx_valid held across two bytes
    r0 = rise_cnt;
    tx_data  = 8'hAE;
    tx_dc    = 1'b0;
    tx_valid = 1'b1;
    tick();
    check("ae_accept_cs", cs, 1'b0);
    exp_q.push_back({1'b0, 8'hAE});
    tx_data = 8'hFF;
    tx_dc   = 1'b1;
    exp_q.push_back({1'b1, 8'hFF});
    gap = 0;
    n = 0;
    seen_high = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (cs === 1'b1 && tx_ready === 1'b0) gap++;
      if (cs === 1'b1) seen_high = 1'b1;
      else if (seen_high) break;
    end
    tx_valid = 1'b0;
    check("b2b_gap_cycles", gap, CS_GAP);
    check("b2b_second_dc", dc, 1'b1);
    wait_ready(lat);
    check("b2b_latency", lat, LAT);
    check("b2b_rises", rise_cnt - r0, 16);

    // 6: input changes after accept do not affect the byte in flight
    send(8'h81, 1'b0);
    tx_data = 8'h00;
    tx_dc   = 1'b1;
    wait_ready(lat);
    check("81_latency", lat, LAT);

    // 5: reset after the 3rd rising edge of a byte
    send(8'h5A, 1'b1);
    void'(exp_q.pop_back());
    r0 = rise_cnt;
    n = 0;
    while ((rise_cnt - r0) < 3 && n < 100) begin
      tick();
      n++;
    end
    check("abort_rises", rise_cnt - r0, 3);
    rst = 1'b1;
    tick();
    rx_n = 0;
    check("abort_cs", cs, 1'b1);
    check("abort_oled_clk", oled_clk, 1'b0);
    check("abort_res", res, 1'b0);
    check("abort_ready", tx_ready, 1'b0);
    check("abort_init", init_done, 1'b0);

    // 4: request held through the replayed reset sequence
    tick();
    rst      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h3F;
    tx_dc    = 1'b0;
    r0 = rise_cnt;
    cs_bad = 0;
    t_res = 0;
    n = 0;
    while (init_done !== 1'b1 && n < 50) begin
      tick();
      n++;
      if (res === 1'b1 && t_res == 0) t_res = n;
      if (cs !== 1'b1) cs_bad++;
    end
    check("replay_res_rise", t_res, RES_LOW);
    check("replay_init", n, RES_LOW + RES_WAIT);
    check("early_no_rise", rise_cnt - r0, 0);
    check("early_cs_high", cs_bad, 0);
    check("replay_ready", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    exp_q.push_back({1'b0, 8'h3F});
    check("3f_first_idle_accept", cs, 1'b0);
    check("3f_din_msb", din, 1'b0);
    check("3f_ready_low", tx_ready, 1'b0);
    wait_ready(lat);
    check("3f_latency", lat, LAT);
    for (int i = 0; i < 4; i++) tick();

    // Scoreboard drain
    check("byte_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("byte_dc_data", got_q.pop_front(), exp_q.pop_front());
    check("edge_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
